// File: rtl/cpu_parameters.sv
// rtl/cpu_parameters.sv - core-wide width parameters for intirvx
package cpu_parameters;
  localparam int xlen = 32;
endpackage

// File: rtl/interfaces_pkg.sv
// rtl/interfaces_pkg.sv - write-back stage types shared by top and arbiter
package interfaces_pkg;
  localparam int WB_XLEN = cpu_parameters::xlen;

  typedef enum logic [0:0] {
    WB_RUN      = 1'b0,
    WB_REDIRECT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic [4:0]         rd;
    logic               jump;
    logic [WB_XLEN-1:0] jump_addr;
  } wb_entry_t;
endpackage

// File: rtl/intirvx_wb_arbiter.sv
// rtl/intirvx_wb_arbiter.sv - 2:1 fixed-priority select of ALU/LSU write-back entries
module intirvx_wb_arbiter
  import interfaces_pkg::*;
#(
  parameter int LSU_PRIO = 1
) (
  input  wb_entry_t alu_entry,
  input  logic      alu_valid,
  input  wb_entry_t lsu_entry,
  input  logic      lsu_valid,
  input  logic      enable,
  output logic      alu_ready,
  output logic      lsu_ready,
  output wb_entry_t sel_entry,
  output logic      sel_valid
);

  // Priority source sees ready whenever enabled; the other only when the priority source is idle
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    sel_entry = '0;
    sel_valid = 1'b0;
    if (LSU_PRIO != 0) begin
      lsu_ready = enable;
      alu_ready = enable & ~lsu_valid;
    end else begin
      alu_ready = enable;
      lsu_ready = enable & ~alu_valid;
    end
    if (lsu_valid && lsu_ready) begin
      sel_entry = lsu_entry;
      sel_valid = 1'b1;
    end else if (alu_valid && alu_ready) begin
      sel_entry = alu_entry;
      sel_valid = 1'b1;
    end
  end

endmodule

// File: rtl/intirvx_writeback.sv
// rtl/intirvx_writeback.sv - intirvx write-back stage; optional INTIRVX_WB_RETIRE_CNT_EN adds retire_cnt
module intirvx_writeback
  import interfaces_pkg::*;
#(
  parameter int XLEN     = cpu_parameters::xlen,
  parameter int LSU_PRIO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] alu_result,
  input  logic [4:0]      alu_rd,
  input  logic            alu_jump,
  input  logic [XLEN-1:0] alu_jump_addr,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [XLEN-1:0] lsu_result,
  input  logic [4:0]      lsu_rd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [XLEN-1:0] pc_jump_addr,
  output logic            pc_valid,
  input  logic            pc_ready,
`ifdef INTIRVX_WB_RETIRE_CNT_EN
  output logic [63:0]     retire_cnt,
`endif
  output logic            flush
);

  localparam logic [0:0] S_RUN      = 1'b0;
  localparam logic [0:0] S_REDIRECT = 1'b1;

  logic [0:0] state;
  wb_entry_t  alu_entry;
  wb_entry_t  lsu_entry;
  wb_entry_t  sel_entry;
  logic       sel_valid;
  logic       enable;

  // Loads never redirect, so the LSU entry carries a cleared jump request
  always_comb begin
    alu_entry           = '0;
    alu_entry.data      = alu_result;
    alu_entry.rd        = alu_rd;
    alu_entry.jump      = alu_jump;
    alu_entry.jump_addr = alu_jump_addr;
    lsu_entry           = '0;
    lsu_entry.data      = lsu_result;
    lsu_entry.rd        = lsu_rd;
  end

  // Readies are held low while a redirect is pending and while reset is asserted
  assign enable = (state == S_RUN) && rst_n;

  intirvx_wb_arbiter #(
    .LSU_PRIO (LSU_PRIO)
  ) u_arbiter (
    .alu_entry (alu_entry),
    .alu_valid (alu_valid),
    .lsu_entry (lsu_entry),
    .lsu_valid (lsu_valid),
    .enable    (enable),
    .alu_ready (alu_ready),
    .lsu_ready (lsu_ready),
    .sel_entry (sel_entry),
    .sel_valid (sel_valid)
  );

  // Register-file write port: one accepted entry lands one cycle later, x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= sel_valid && (sel_entry.rd != 5'd0);
      if (sel_valid) begin
        rf_waddr <= sel_entry.rd;
        rf_wdata <= sel_entry.data;
      end
    end
  end

  // Jump FSM: flush pulses once on acceptance, the redirect is held until the PC unit takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RUN;
      pc_valid     <= 1'b0;
      pc_jump_addr <= '0;
      flush        <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        S_RUN: begin
          if (sel_valid && sel_entry.jump) begin
            state        <= S_REDIRECT;
            pc_valid     <= 1'b1;
            pc_jump_addr <= {sel_entry.jump_addr[XLEN-1:1], 1'b0};
            flush        <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (pc_valid && pc_ready) begin
            state    <= S_RUN;
            pc_valid <= 1'b0;
          end
        end
        default: begin
          state    <= S_RUN;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTIRVX_WB_RETIRE_CNT_EN
  // Every accepted entry retires, including jumps and x0 writes; wraps naturally at 2^64
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 64'd0;
    end else if (sel_valid) begin
      retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule
